// File: rtl/lbp_host_pkg.sv
// Shared types and defaults for the LBP image host: FSM state encoding,
// default frame geometry and the border-address predicate.
package lbp_host_pkg;

  localparam int unsigned DEF_IMG_W = 128;
  localparam int unsigned DEF_IMG_H = 128;
  localparam int unsigned DEF_AW    = 14;
  localparam int unsigned DEF_DW    = 8;

  typedef enum logic [1:0] {
    LOAD,
    SERVE,
    DUMP,
    DONE
  } host_state_e;

  // Width and height are powers of two, so the divide/modulo reduce to wiring.
  function automatic logic is_border(input logic [31:0] addr,
                                     input int unsigned img_w,
                                     input int unsigned img_h);
    int unsigned row;
    int unsigned col;
    row = addr / img_w;
    col = addr % img_w;
    return (row == 0) || (row == img_h - 1) || (col == 0) || (col == img_w - 1);
  endfunction

endpackage

// File: rtl/lbp_img_host_if.sv
// Bundle of the load, gray-read, LBP-write and dump-stream signals of the
// LBP image host. master = frame DMA / engine / sink side, slave = host.
interface lbp_img_host_if #(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 8
) ();

  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [DW-1:0] lbp_data;
  logic          finish;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic          done;
  logic          protocol_err;

  modport master (
    output ld_valid, ld_data, gray_req, gray_addr, lbp_valid, lbp_addr,
           lbp_data, finish, rd_ready,
    input  ld_ready, gray_ready, gray_data, rd_valid, rd_data, done,
           protocol_err
  );

  modport slave (
    input  ld_valid, ld_data, gray_req, gray_addr, lbp_valid, lbp_addr,
           lbp_data, finish, rd_ready,
    output ld_ready, gray_ready, gray_data, rd_valid, rd_data, done,
           protocol_err
  );

endinterface

// File: rtl/lbp_host_ram.sv
// Generic 1R1W synchronous RAM, depth 2**AW, registered read data that
// holds its value while i_re is low. No reset on the array or read port.
module lbp_host_ram #(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lbp_img_host.sv
// LBP engine host: loads a gray frame, serves engine reads, captures LBP
// results and dumps them in raster order. Optional checker: LBP_HOST_PROTOCOL_CHECK_EN.
module lbp_img_host
  import lbp_host_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned DW    = DEF_DW
) (
  input  logic           clk,
  input  logic           reset,
  lbp_img_host_if.slave  bus
);

  localparam int unsigned   NPIX = IMG_W * IMG_H;
  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  host_state_e   r_state;
  logic [AW-1:0] r_ld_cnt;
  logic [AW-1:0] r_fetch;
  logic          r_fetch_done;
  logic          r_ld_ready;
  logic          r_gray_ready;
  logic          r_gray_vld;
  logic          r_rd_valid;
  logic          r_rd_border;
  logic          r_done;

  logic          w_ld_acc;
  logic          w_gray_rd;
  logic          w_lbp_wr;
  logic          w_fetch;
  logic [DW-1:0] w_gray_q;
  logic [DW-1:0] w_lbp_q;

  assign w_ld_acc  = bus.ld_valid && r_ld_ready;
  assign w_gray_rd = bus.gray_req && (r_state == SERVE);
  assign w_lbp_wr  = bus.lbp_valid && (r_state == SERVE);
  // Prefetch refills the single output slot whenever it is empty or being drained.
  assign w_fetch   = (r_state == DUMP) && !r_fetch_done && (!r_rd_valid || bus.rd_ready);

  lbp_host_ram #(.AW(AW), .DW(DW)) u_gray_mem (
    .clk     (clk),
    .i_we    (w_ld_acc),
    .i_waddr (r_ld_cnt),
    .i_wdata (bus.ld_data),
    .i_re    (w_gray_rd),
    .i_raddr (bus.gray_addr),
    .o_rdata (w_gray_q)
  );

  lbp_host_ram #(.AW(AW), .DW(DW)) u_lbp_mem (
    .clk     (clk),
    .i_we    (w_lbp_wr),
    .i_waddr (bus.lbp_addr),
    .i_wdata (bus.lbp_data),
    .i_re    (w_fetch),
    .i_raddr (r_fetch),
    .o_rdata (w_lbp_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= LOAD;
      r_ld_cnt     <= '0;
      r_fetch      <= '0;
      r_fetch_done <= 1'b0;
      r_ld_ready   <= 1'b0;
      r_gray_ready <= 1'b0;
      r_gray_vld   <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_border  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_ld_ready <= 1'b1;
          if (w_ld_acc) begin
            r_ld_cnt <= r_ld_cnt + 1'b1;
            if (r_ld_cnt == LAST) begin
              r_ld_ready   <= 1'b0;
              r_gray_ready <= 1'b1;
              r_state      <= SERVE;
            end
          end
        end
        SERVE: begin
          if (w_gray_rd) r_gray_vld <= 1'b1;
          if (bus.finish) begin
            r_gray_ready <= 1'b0;
            r_fetch      <= '0;
            r_fetch_done <= 1'b0;
            r_state      <= DUMP;
          end
        end
        DUMP: begin
          if (w_fetch) begin
            r_rd_valid  <= 1'b1;
            r_rd_border <= is_border(32'(r_fetch), IMG_W, IMG_H);
            r_fetch     <= r_fetch + 1'b1;
            if (r_fetch == LAST) r_fetch_done <= 1'b1;
          end else if (r_fetch_done && r_rd_valid && bus.rd_ready) begin
            r_rd_valid <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ld_ready   = r_ld_ready;
  assign bus.gray_ready = r_gray_ready;
  assign bus.gray_data  = r_gray_vld ? w_gray_q : '0;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_data    = (r_rd_valid && !r_rd_border) ? w_lbp_q : '0;
  assign bus.done       = r_done;

`ifdef LBP_HOST_PROTOCOL_CHECK_EN
  localparam int unsigned N_INT = (IMG_W - 2) * (IMG_H - 2);

  logic [NPIX-1:0] r_written;
  logic [AW:0]     r_int_cnt;
  logic            r_perr;
  logic            w_lbp_border;

  assign w_lbp_border = is_border(32'(bus.lbp_addr), IMG_W, IMG_H);

  // r_int_cnt counts distinct interior addresses written so finish can be judged in one compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_written <= '0;
      r_int_cnt <= '0;
      r_perr    <= 1'b0;
    end else begin
      if (w_lbp_wr && !w_lbp_border && !r_written[bus.lbp_addr]) begin
        r_written[bus.lbp_addr] <= 1'b1;
        r_int_cnt               <= r_int_cnt + 1'b1;
      end
      if ((bus.lbp_valid && w_lbp_border) ||
          ((bus.lbp_valid || bus.gray_req) && (r_state != SERVE)) ||
          (bus.finish && (r_state == SERVE) && (r_int_cnt != (AW+1)'(N_INT))))
        r_perr <= 1'b1;
    end
  end

  assign bus.protocol_err = r_perr;
`else
  assign bus.protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_lbp_img_host.sv
// Directed bench for lbp_img_host: ramp load, gray reads, LBP writes,
// stalled dump against a hand-built expected frame, and mid-SERVE reset.
module tb_lbp_img_host;

  localparam int unsigned NPIX = 16384;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  lbp_img_host_if #(.AW(14), .DW(8)) bus ();

  lbp_img_host #(.IMG_W(128), .IMG_H(128), .AW(14), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < int'(NPIX); i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'(i);
      tick();
      if (i == int'(NPIX) - 2) begin
        chk("gray_ready_before_last", 32'(bus.gray_ready), 32'd0);
        chk("ld_ready_before_last", 32'(bus.ld_ready), 32'd1);
      end
    end
    bus.ld_valid = 1'b0;
  endtask

  logic [7:0]  exp_pix [NPIX];
  logic [13:0] av;
  logic [7:0]  held_data;
  logic        held_valid;
  logic        rdy;
  logic [7:0]  p0, p127, p129, p16254;
  int          cnt, cyc, bad_pix, stall_bad;
  logic [31:0] pe_exp;

  initial begin
    checks = 0;
    errors = 0;
`ifdef LBP_HOST_PROTOCOL_CHECK_EN
    pe_exp = 32'd1;
`else
    pe_exp = 32'd0;
`endif
    reset         = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.gray_req  = 1'b0;
    bus.gray_addr = '0;
    bus.lbp_valid = 1'b0;
    bus.lbp_addr  = '0;
    bus.lbp_data  = '0;
    bus.finish    = 1'b0;
    bus.rd_ready  = 1'b0;

    for (int a = 0; a < int'(NPIX); a++) begin
      av = 14'(a);
      if (av[13:7] == 7'd0 || av[13:7] == 7'd127 || av[6:0] == 7'd0 || av[6:0] == 7'd127)
        exp_pix[a] = 8'h00;
      else if (a == 16254)
        exp_pix[a] = 8'h33;
      else
        exp_pix[a] = av[7:0] ^ 8'h5A;
    end

    tick();
    tick();
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_gray_ready", 32'(bus.gray_ready), 32'd0);
    chk("rst_gray_data", 32'(bus.gray_data), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_protocol_err", 32'(bus.protocol_err), 32'd0);
    reset = 1'b1;
    tick();
    chk("ld_ready_after_release", 32'(bus.ld_ready), 32'd1);

    load_ramp();
    chk("ld_ready_after_last", 32'(bus.ld_ready), 32'd0);
    chk("gray_ready_after_last", 32'(bus.gray_ready), 32'd1);

    bus.gray_req = 1'b1; bus.gray_addr = 14'd129;
    tick();
    bus.gray_req = 1'b0;
    chk("gray_data_129", 32'(bus.gray_data), 32'h81);
    tick();
    chk("gray_data_129_held", 32'(bus.gray_data), 32'h81);

    bus.gray_req = 1'b1; bus.gray_addr = 14'd0;
    tick();
    chk("gray_b2b_0", 32'(bus.gray_data), 32'h00);
    bus.gray_addr = 14'd1;
    tick();
    chk("gray_b2b_1", 32'(bus.gray_data), 32'h01);
    bus.gray_addr = 14'd16383;
    tick();
    chk("gray_b2b_16383", 32'(bus.gray_data), 32'hFF);
    bus.gray_req = 1'b0;

    // Early overwrites of 129 and 16254 exercise last-write-wins.
    bus.lbp_valid = 1'b1; bus.lbp_addr = 14'd129; bus.lbp_data = 8'h00;
    tick();
    bus.lbp_addr = 14'd16254; bus.lbp_data = 8'hEE;
    tick();
    for (int a = 0; a < int'(NPIX); a++) begin
      av = 14'(a);
      if (!(av[13:7] == 7'd0 || av[13:7] == 7'd127 || av[6:0] == 7'd0 || av[6:0] == 7'd127)) begin
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = av;
        bus.lbp_data  = av[7:0] ^ 8'h5A;
        tick();
      end
    end
    bus.lbp_addr = 14'd16254; bus.lbp_data = 8'h33; bus.finish = 1'b1;
    tick();
    bus.lbp_valid = 1'b0; bus.finish = 1'b0;
    chk("gray_ready_after_finish", 32'(bus.gray_ready), 32'd0);
    chk("done_before_dump", 32'(bus.done), 32'd0);
    chk("protocol_err_clean_frame", 32'(bus.protocol_err), 32'd0);

    cnt = 0; cyc = 0; bad_pix = 0; stall_bad = 0; held_valid = 1'b0;
    p0 = 8'hxx; p127 = 8'hxx; p129 = 8'hxx; p16254 = 8'hxx;
    while (cnt < int'(NPIX) && cyc < 60000) begin
      if (held_valid && (bus.rd_valid !== 1'b1 || bus.rd_data !== held_data)) stall_bad++;
      held_valid = 1'b0;
      rdy = ($urandom_range(0, 3) != 0);
      bus.rd_ready = rdy;
      if (bus.rd_valid === 1'b1) begin
        if (rdy) begin
          if (bus.rd_data !== exp_pix[cnt]) bad_pix++;
          if (cnt == 0) p0 = bus.rd_data;
          if (cnt == 127) p127 = bus.rd_data;
          if (cnt == 129) p129 = bus.rd_data;
          if (cnt == 16254) p16254 = bus.rd_data;
          cnt++;
        end else begin
          held_valid = 1'b1;
          held_data  = bus.rd_data;
        end
      end
      tick();
      cyc++;
    end
    bus.rd_ready = 1'b0;
    chk("dump_count", 32'(cnt), 32'(NPIX));
    chk("dump_pixel_mismatches", 32'(bad_pix), 32'd0);
    chk("dump_stall_hold_violations", 32'(stall_bad), 32'd0);
    chk("dump_pix0_border", 32'(p0), 32'h00);
    chk("dump_pix127_border", 32'(p127), 32'h00);
    chk("dump_pix129", 32'(p129), 32'hDB);
    chk("dump_pix16254_finish_write", 32'(p16254), 32'h33);
    chk("done_after_last", 32'(bus.done), 32'd1);
    chk("rd_valid_after_last", 32'(bus.rd_valid), 32'd0);
    tick();
    chk("done_sticky", 32'(bus.done), 32'd1);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    load_ramp();
    chk("reload_gray_ready", 32'(bus.gray_ready), 32'd1);
    bus.gray_req = 1'b1; bus.gray_addr = 14'd129;
    tick();
    bus.gray_req = 1'b0;
    chk("reload_gray_data_129", 32'(bus.gray_data), 32'h81);

    bus.lbp_valid = 1'b1; bus.lbp_addr = 14'd0; bus.lbp_data = 8'h11;
    tick();
    bus.lbp_valid = 1'b0;
    chk("protocol_err_border_write", 32'(bus.protocol_err), pe_exp);
    tick();
    tick();
    chk("protocol_err_sticky", 32'(bus.protocol_err), pe_exp);

    #2;
    reset = 1'b0;
    #1;
    chk("midreset_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("midreset_gray_ready", 32'(bus.gray_ready), 32'd0);
    chk("midreset_gray_data", 32'(bus.gray_data), 32'd0);
    chk("midreset_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("midreset_rd_data", 32'(bus.rd_data), 32'd0);
    chk("midreset_done", 32'(bus.done), 32'd0);
    chk("midreset_protocol_err", 32'(bus.protocol_err), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("midreset_ld_ready_release", 32'(bus.ld_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lbp_img_host.md
Name: lbp_img_host

Overview:
Responder/sink for the LBP engine's gray-read and LBP-write interfaces. It is loaded with a 128x128 grayscale frame over a byte stream, then raises gray_ready and serves gray_addr reads. It captures lbp_addr/lbp_data writes into a result buffer and, after the engine's finish, streams the full LBP frame out in raster order. It is the synthesizable counterpart that sits between frame DMA and the LBP engine.

Parameters:
IMG_W, 128, image width in pixels (power of 2)
IMG_H, 128, image height in pixels (power of 2)
AW, 14, address width; log2(IMG_W*IMG_H)
DW, 8, pixel/LBP data width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
ld_valid  in  1  load-stream pixel valid
ld_data  in  DW  load-stream pixel, raster order
ld_ready  out  1  host accepts load pixel
gray_ready  out  1  frame loaded; engine may read
gray_req  in  1  engine read request
gray_addr  in  AW  engine read address
gray_data  out  DW  read data, 1-cycle latency
lbp_valid  in  1  engine result write strobe
lbp_addr  in  AW  result address
lbp_data  in  DW  result value
finish  in  1  engine done
rd_valid  out  1  dump-stream data valid
rd_data  out  DW  dump-stream LBP pixel, raster order
rd_ready  in  1  downstream accepts dump pixel
done  out  1  whole frame dumped
protocol_err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (reset=0): state LOAD; ld_ready=0, gray_ready=0, gray_data=0, rd_valid=0, rd_data=0, done=0, protocol_err=0; load/dump counters=0. Memory contents are not cleared.
- State LOAD: ld_ready=1 (registered, high from the first cycle after reset release). A pixel is accepted when ld_valid&&ld_ready. It is written to gray_mem[ld_cnt], and ld_cnt increments. On acceptance of pixel IMG_W*IMG_H-1: ld_ready drops, the state moves to SERVE, and gray_ready=1 from the next cycle. gray_req, lbp_valid and finish are ignored in LOAD.
- State SERVE: gray_ready=1. If gray_req=1 at posedge N, gray_data=gray_mem[gray_addr] from posedge N. It is held until the next accepted request. Back-to-back requests are supported, one per cycle.
- lbp_valid=1 at a posedge writes lbp_mem[lbp_addr]=lbp_data; the last write to the same address wins.
- finish=1 sampled in SERVE: gray_ready drops next cycle and the state moves to DUMP. A write in the same cycle as finish is committed. finish is level-sampled; subsequent cycles are ignored.
- State DUMP: rd_valid=1, rd_data=pixel at dump_cnt. dump_cnt advances only on rd_valid&&rd_ready. rd_data is stable while stalled.
- Border addresses (row 0, row IMG_H-1, col 0, col IMG_W-1) dump as 0 regardless of lbp_mem. Interior addresses dump the lbp_mem contents.
- Memory read latency is hidden by a one-entry prefetch; there are no bubbles under continuous rd_ready.
- After the handshake on address IMG_W*IMG_H-1: rd_valid=0, the state moves to DONE, and done=1 sticky until reset.
- Address arithmetic: counters are AW bits wide. row=addr[AW-1:log2(IMG_W)], col=addr[log2(IMG_W)-1:0].
- Reset mid-operation: immediate return to LOAD with all outputs at reset values. A new frame must be reloaded.

Optional Feature:
Macro LBP_HOST_PROTOCOL_CHECK_EN.
- Defined: protocol_err is set (sticky) on any of:
  - lbp_valid to a border address
  - lbp_valid or gray_req outside SERVE
  - finish in SERVE before every interior address has been written at least once (tracked with a per-address written bitmap)
- Undefined: no checker logic or bitmap is built; protocol_err is tied 0.

Decomposition:
- Package lbp_host_pkg: state enum (LOAD, SERVE, DUMP, DONE), IMG_W/IMG_H/AW/DW defaults, and an is_border(addr) function.
- One sub-module: lbp_host_ram, a generic 1R1W synchronous RAM of depth 2**AW and width DW, instantiated twice (gray_mem and lbp_mem).
- FSM and counters stay in the top.

Test Plan:
- Load ramp pixel=addr[7:0] -> ld_ready drops after 16384 pixels; gray_ready=1 next cycle; gray_req addr 129 -> gray_data=0x81 one cycle later.
- Back-to-back gray_req addrs 0,1,16383 -> gray_data 0x00,0x01,0xFF on consecutive cycles.
- Write lbp_data=addr[7:0]^0x5A for every interior address, assert finish -> dump yields 16384 pixels: borders 0, interior addr 129 = 0xDB; done=1 after last handshake.
- During DUMP, toggle rd_ready 0/1 randomly -> rd_data is held while stalled; no loss or duplication; total count 16384.
- lbp_valid together with finish on addr 16254 data 0x33 -> dumped pixel 16254 = 0x33.
- Assert reset mid-SERVE -> all outputs 0 immediately, ld_ready=1 after release. With macro on: write to addr 0 -> protocol_err=1 and sticky.
